// File: rtl/vga_rx_timing.sv
// Receive-side VGA timing recovery: samples hsync/vsync/RGB565, measures line and
// frame lengths, locks to the configured mode and recovers pix_x/pix_y/pix_data.
// Ports: vga_clk/sys_rst_n (sync active-low); hsync, vsync, rgb[15:0] pin inputs;
//   pix_x/pix_y/pix_data/pix_valid recovered pixel view (2 cycles after the pins);
//   frame_start, locked, err status; h_total_meas/v_total_meas last measured totals.
module vga_rx_timing #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_ACT_START = 144,
  parameter int V_ACT_START = 35,
  parameter int H_VALID     = 640,
  parameter int V_VALID     = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [15:0] rgb,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [15:0] pix_data,
  output logic        pix_valid,
  output logic        frame_start,
  output logic        locked,
  output logic        err,
  output logic [11:0] h_total_meas,
  output logic [10:0] v_total_meas
);

  localparam logic [11:0] H_TOT  = 12'(H_TOTAL);
  localparam logic [10:0] V_TOT  = 11'(V_TOTAL);
  localparam logic [11:0] H_LO   = 12'(H_ACT_START);
  localparam logic [11:0] H_HI   = 12'(H_ACT_START + H_VALID - 1);
  localparam logic [10:0] V_LO   = 11'(V_ACT_START);
  localparam logic [10:0] V_HI   = 11'(V_ACT_START + V_VALID - 1);
  localparam logic [3:0]  LOCK_N = 4'(LOCK_FRAMES);
  localparam logic [11:0] H_MAX  = 12'hFFF;
  localparam logic [10:0] V_MAX  = 11'h7FF;

  typedef enum logic [1:0] {ST_SEARCH, ST_CHECK, ST_LOCKED} state_t;

  state_t      state_q, state_d;
  logic        hs_s_q, hs_s_d, vs_s_q, vs_s_d;     // stage-1 samples
  logic        hs_p_q, hs_p_d, vs_p_q, vs_p_d;     // previous samples for edge detect
  logic [15:0] rgb_s_q, rgb_s_d;
  logic [11:0] h_cnt_q, h_cnt_d;
  logic [10:0] v_cnt_q, v_cnt_d;
  logic        v_pend_q, v_pend_d;                 // vsync edge seen, line reset pending
  logic        bad_seen_q, bad_seen_d;             // a bad line occurred in this frame
  logic [3:0]  good_cnt_q, good_cnt_d;
  logic [11:0] h_meas_q, h_meas_d;
  logic [10:0] v_meas_q, v_meas_d;
  logic [9:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [15:0] pix_data_q, pix_data_d;
  logic        pix_valid_q, pix_valid_d;
  logic        frame_start_q, frame_start_d;
  logic        locked_q, locked_d;
  logic        err_q, err_d;

  logic hs_rise, vs_rise, line_good, line_bad, timeout, frame_good, in_act;

  always_comb begin
    hs_s_d  = hsync;
    vs_s_d  = vsync;
    rgb_s_d = rgb;
    hs_p_d  = hs_s_q;
    vs_p_d  = vs_s_q;

    hs_rise   = hs_s_q & ~hs_p_q;
    vs_rise   = vs_s_q & ~vs_p_q;
    line_good = (h_cnt_q + 12'd1) == H_TOT;
    line_bad  = hs_rise & ~line_good;
    // Saturation means hsync has gone missing for too long.
    timeout   = (h_cnt_q == H_MAX) & ~hs_rise;
    // A line ending on the same edge as the vsync still belongs to the closing frame.
    frame_good = ((v_cnt_q + 11'd1) == V_TOT) & ~bad_seen_q & ~line_bad & ~timeout;

    h_cnt_d  = hs_rise ? 12'd0 : ((h_cnt_q == H_MAX) ? H_MAX : h_cnt_q + 12'd1);
    h_meas_d = h_meas_q;
    if (hs_rise) h_meas_d = (h_cnt_q == H_MAX) ? H_MAX : h_cnt_q + 12'd1;

    v_pend_d = v_pend_q;
    if (hs_rise)      v_pend_d = 1'b0;
    else if (vs_rise) v_pend_d = 1'b1;

    v_cnt_d = v_cnt_q;
    if (hs_rise) v_cnt_d = (vs_rise | v_pend_q) ? 11'd0
                         : ((v_cnt_q == V_MAX) ? V_MAX : v_cnt_q + 11'd1);

    v_meas_d = v_meas_q;
    if (vs_rise) v_meas_d = (v_cnt_q == V_MAX) ? V_MAX : v_cnt_q + 11'd1;

    bad_seen_d = bad_seen_q;
    if (vs_rise)                  bad_seen_d = 1'b0;
    else if (line_bad | timeout)  bad_seen_d = 1'b1;

    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    err_d      = 1'b0;
    case (state_q)
      ST_SEARCH: begin
        if (vs_rise) begin
          state_d    = ST_CHECK;
          good_cnt_d = 4'd0;
        end
      end
      ST_CHECK: begin
        if (timeout) begin
          state_d = ST_SEARCH;
        end else if (vs_rise) begin
          if (frame_good) begin
            good_cnt_d = good_cnt_q + 4'd1;
            if (good_cnt_q + 4'd1 == LOCK_N) state_d = ST_LOCKED;
          end else begin
            good_cnt_d = 4'd0;
          end
        end
      end
      ST_LOCKED: begin
        if (line_bad | timeout | (vs_rise & ~frame_good)) begin
          err_d   = 1'b1;
          state_d = ST_SEARCH;
        end
      end
      default: state_d = ST_SEARCH;
    endcase

    locked_d      = (state_d == ST_LOCKED);
    frame_start_d = vs_rise;

    // Next-state counters line up with the stage-1 rgb sample being registered.
    in_act = locked_d & (h_cnt_d >= H_LO) & (h_cnt_d <= H_HI)
                      & (v_cnt_d >= V_LO) & (v_cnt_d <= V_HI);
    pix_valid_d = in_act;
    pix_x_d     = in_act ? 10'(h_cnt_d - H_LO) : 10'd0;
    pix_y_d     = in_act ? 10'(v_cnt_d - V_LO) : 10'd0;
    pix_data_d  = in_act ? rgb_s_q : 16'd0;
  end

  always_ff @(posedge vga_clk) begin
    if (!sys_rst_n) begin
      state_q       <= ST_SEARCH;
      hs_s_q        <= 1'b0;
      vs_s_q        <= 1'b0;
      hs_p_q        <= 1'b0;
      vs_p_q        <= 1'b0;
      rgb_s_q       <= '0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      v_pend_q      <= 1'b0;
      bad_seen_q    <= 1'b0;
      good_cnt_q    <= '0;
      h_meas_q      <= '0;
      v_meas_q      <= '0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_data_q    <= '0;
      pix_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      locked_q      <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      hs_s_q        <= hs_s_d;
      vs_s_q        <= vs_s_d;
      hs_p_q        <= hs_p_d;
      vs_p_q        <= vs_p_d;
      rgb_s_q       <= rgb_s_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      v_pend_q      <= v_pend_d;
      bad_seen_q    <= bad_seen_d;
      good_cnt_q    <= good_cnt_d;
      h_meas_q      <= h_meas_d;
      v_meas_q      <= v_meas_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      pix_data_q    <= pix_data_d;
      pix_valid_q   <= pix_valid_d;
      frame_start_q <= frame_start_d;
      locked_q      <= locked_d;
      err_q         <= err_d;
    end
  end

  assign pix_x        = pix_x_q;
  assign pix_y        = pix_y_q;
  assign pix_data     = pix_data_q;
  assign pix_valid    = pix_valid_q;
  assign frame_start  = frame_start_q;
  assign locked       = locked_q;
  assign err          = err_q;
  assign h_total_meas = h_meas_q;
  assign v_total_meas = v_meas_q;

endmodule

// File: tb/tb_vga_rx_timing.sv
// Bench for vga_rx_timing using a reduced video mode so whole frames stay short.
module tb_vga_rx_timing;

  localparam int HT  = 24;
  localparam int VT  = 10;
  localparam int HAS = 6;
  localparam int VAS = 2;
  localparam int HV  = 12;
  localparam int VV  = 6;
  localparam int LF  = 2;

  logic        vga_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        hsync = 1'b0, vsync = 1'b0;
  logic [15:0] rgb = 16'd0;
  logic [9:0]  pix_x, pix_y;
  logic [15:0] pix_data;
  logic        pix_valid, frame_start, locked, err;
  logic [11:0] h_total_meas;
  logic [10:0] v_total_meas;

  vga_rx_timing #(
    .H_TOTAL(HT), .V_TOTAL(VT), .H_ACT_START(HAS), .V_ACT_START(VAS),
    .H_VALID(HV), .V_VALID(VV), .LOCK_FRAMES(LF)
  ) dut (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data), .pix_valid(pix_valid),
    .frame_start(frame_start), .locked(locked), .err(err),
    .h_total_meas(h_total_meas), .v_total_meas(v_total_meas)
  );

  always #20 vga_clk = ~vga_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge vga_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard of {pix_x, pix_y, pix_data} for pixels that should come out valid.
  logic [35:0] sb_q[$];

  int pv_cnt = 0, fs_cnt = 0, err_cnt = 0, lock_cyc_cnt = 0;
  int fs_last = 0, fs_prev = 0, err_cyc = 0, lock_rise_cyc = 0, lock_fall_cyc = 0;
  logic locked_prev = 1'b0;

  always @(negedge vga_clk) begin
    if (pix_valid === 1'b1) begin
      pv_cnt++;
      if (sb_q.size() == 0) begin
        check("pv_unexpected", 64'(pix_valid), 64'd0);
      end else begin
        logic [35:0] e;
        e = sb_q.pop_front();
        check("pix", 64'({pix_x, pix_y, pix_data}), 64'(e));
      end
    end
    if (frame_start === 1'b1) begin
      fs_cnt++;
      fs_prev = fs_last;
      fs_last = cyc;
    end
    if (err === 1'b1) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (locked === 1'b1 && locked_prev !== 1'b1) lock_rise_cyc = cyc;
    if (locked !== 1'b1 && locked_prev === 1'b1) lock_fall_cyc = cyc;
    if (locked === 1'b1) lock_cyc_cnt++;
    locked_prev = locked;
  end

  int frame_cyc = 0, glitch_cyc = 0, last_line_cyc = 0;

  // One frame: hsync high for 3 clocks, vsync high for lines 0-1 (edges coincide).
  // short_line (if >=0) is one clock short; active pixels of lines < push_lines are queued.
  task automatic drive_frame(input int line_len, input int short_line,
                             input int n_lines, input int push_lines);
    for (int v = 0; v < n_lines; v++) begin
      int len;
      len = (v == short_line) ? line_len - 1 : line_len;
      for (int h = 0; h < len; h++) begin
        logic        act;
        logic [9:0]  xv, yv;
        logic [15:0] px;
        @(posedge vga_clk);
        #1;
        act = (h >= HAS) && (h < HAS + HV) && (v >= VAS) && (v < VAS + VV);
        xv  = 10'(h - HAS);
        yv  = 10'(v - VAS);
        px  = {xv[4:0], yv[5:0], xv[4:0]};
        hsync = (h < 3);
        vsync = (v < 2);
        rgb   = act ? px : 16'hA5A5;
        if (h == 0 && v == 0) frame_cyc = cyc;
        if (h == 0 && v == short_line + 1) glitch_cyc = cyc;
        if (h == 0 && v == n_lines - 1) last_line_cyc = cyc;
        if (act && v < push_lines) sb_q.push_back({xv, yv, px});
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge vga_clk);
      #1;
      hsync = 1'b0;
      vsync = 1'b0;
      rgb   = 16'd0;
    end
  endtask

  task automatic check_all_zero(input string ph);
    check({ph, "_pix_x"},     64'(pix_x), 64'd0);
    check({ph, "_pix_y"},     64'(pix_y), 64'd0);
    check({ph, "_pix_data"},  64'(pix_data), 64'd0);
    check({ph, "_pix_valid"}, 64'(pix_valid), 64'd0);
    check({ph, "_frame_st"},  64'(frame_start), 64'd0);
    check({ph, "_locked"},    64'(locked), 64'd0);
    check({ph, "_err"},       64'(err), 64'd0);
    check({ph, "_h_meas"},    64'(h_total_meas), 64'd0);
    check({ph, "_v_meas"},    64'(v_total_meas), 64'd0);
  endtask

  initial begin
    int f2, f3, pv0, fs0, e0, lk0;
    // Reset values
    repeat (3) @(posedge vga_clk);
    #1;
    check_all_zero("rst");
    sys_rst_n = 1'b1;
    idle(5);

    // Clean stream: lock after the first edge plus LF full frames
    pv0 = pv_cnt; fs0 = fs_cnt; e0 = err_cnt;
    drive_frame(HT, -1, VT, 0);
    drive_frame(HT, -1, VT, 0);
    drive_frame(HT, -1, VT, VT); f2 = frame_cyc;
    drive_frame(HT, -1, VT, VT); f3 = frame_cyc;
    idle(0);
    check("lock_rise_cyc", 64'(lock_rise_cyc), 64'(f2 + 2));
    check("locked_a", 64'(locked), 64'd1);
    check("h_meas", 64'(h_total_meas), 64'(HT));
    check("v_meas", 64'(v_total_meas), 64'(VT));
    check("fs_count", 64'(fs_cnt - fs0), 64'd4);
    check("fs_period", 64'(fs_last - fs_prev), 64'(HT * VT));
    check("fs_latency", 64'(fs_last), 64'(f3 + 2));
    check("pv_count_a", 64'(pv_cnt - pv0), 64'(2 * HV * VV));
    check("sb_empty_a", 64'(sb_q.size()), 64'd0);
    check("err_none_a", 64'(err_cnt - e0), 64'd0);

    // One short line while locked, then relock
    e0 = err_cnt; pv0 = pv_cnt;
    drive_frame(HT, 4, VT, 5);
    check("glitch_err_cyc", 64'(err_cyc), 64'(glitch_cyc + 2));
    check("glitch_lock_fall", 64'(lock_fall_cyc), 64'(err_cyc));
    check("glitch_unlocked", 64'(locked), 64'd0);
    drive_frame(HT, -1, VT, 0);
    drive_frame(HT, -1, VT, 0);
    drive_frame(HT, -1, VT, VT); f3 = frame_cyc;
    check("glitch_err_cnt", 64'(err_cnt - e0), 64'd1);
    check("relock_cyc", 64'(lock_rise_cyc), 64'(f3 + 2));
    check("pv_count_b", 64'(pv_cnt - pv0), 64'(3 * HV + HV * VV));
    check("sb_empty_b", 64'(sb_q.size()), 64'd0);

    // hsync missing while locked: saturation timeout
    e0 = err_cnt;
    idle(4200);
    check("timeout_err_cyc", 64'(err_cyc), 64'(last_line_cyc + 4098));
    check("timeout_err_cnt", 64'(err_cnt - e0), 64'd1);
    check("timeout_unlocked", 64'(locked), 64'd0);

    // Wrong line length never locks
    lk0 = lock_cyc_cnt; pv0 = pv_cnt;
    for (int f = 0; f < 4; f++) drive_frame(30, -1, VT, 0);
    idle(3);
    check("wrong_lock_cycles", 64'(lock_cyc_cnt - lk0), 64'd0);
    check("wrong_pv", 64'(pv_cnt - pv0), 64'd0);
    check("wrong_h_meas", 64'(h_total_meas), 64'd30);
    check("wrong_v_meas", 64'(v_total_meas), 64'(VT));

    // Lock, then reset mid-frame, then relock from scratch
    drive_frame(HT, -1, VT, 0);
    drive_frame(HT, -1, VT, 0);
    drive_frame(HT, -1, VT, VT); f2 = frame_cyc;
    drive_frame(HT, -1, 5, 5);
    check("pre_rst_lock_cyc", 64'(lock_rise_cyc), 64'(f2 + 2));
    check("pre_rst_locked", 64'(locked), 64'd1);
    @(posedge vga_clk);
    #1;
    sys_rst_n = 1'b0;
    hsync = 1'b0; vsync = 1'b0; rgb = 16'd0;
    @(posedge vga_clk);
    #1;
    check_all_zero("midrst");
    repeat (2) @(posedge vga_clk);
    #1;
    sys_rst_n = 1'b1;
    idle(5);
    pv0 = pv_cnt; e0 = err_cnt;
    drive_frame(HT, -1, VT, 0);
    drive_frame(HT, -1, VT, 0);
    drive_frame(HT, -1, VT, VT); f2 = frame_cyc;
    drive_frame(HT, -1, VT, VT);
    idle(4);
    check("post_rst_lock_cyc", 64'(lock_rise_cyc), 64'(f2 + 2));
    check("post_rst_pv", 64'(pv_cnt - pv0), 64'(2 * HV * VV));
    check("post_rst_err", 64'(err_cnt - e0), 64'd0);
    check("sb_empty_end", 64'(sb_q.size()), 64'd0);
    check("err_total", 64'(err_cnt), 64'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_rx_timing.md
# vga_rx_timing

Receive-side counterpart of the VGA output path: samples an incoming hsync/vsync/RGB565 stream on the pixel clock and measures the line and frame timing. It locks to the configured 640x480@60 timing and recovers pixel coordinates and pixel data for downstream capture logic. It sits after the VGA pins in loopback and capture designs, one clock domain, and presents the same pix_x/pix_y/pix_data view that the output path consumes.

## Interface
- H_TOTAL, 800: expected clocks per line.
- V_TOTAL, 525: expected lines per frame.
- H_ACT_START, 144: clocks from hsync leading edge to first active pixel.
- V_ACT_START, 35: lines from vsync leading edge to first active line.
- H_VALID, 640: active pixels per line.
- V_VALID, 480: active lines per frame.
- LOCK_FRAMES, 2: consecutive good frames needed to lock.
- vga_clk  in  1  pixel clock, 25 MHz.
- sys_rst_n  in  1  synchronous active-low reset, sampled on vga_clk rising edge.
- hsync  in  1  line sync, active high.
- vsync  in  1  field sync, active high.
- rgb  in  16  RGB565 input.
- pix_x  out  10  recovered x coordinate, valid when pix_valid.
- pix_y  out  10  recovered y coordinate, valid when pix_valid.
- pix_data  out  16  registered pixel colour.
- pix_valid  out  1  active-region pixel strobe, asserted only while locked.
- frame_start  out  1  one-cycle pulse at each vsync leading edge.
- locked  out  1  timing lock status.
- err  out  1  one-cycle pulse on a timing mismatch while locked.
- h_total_meas  out  12  last measured line length, in clocks.
- v_total_meas  out  11  last measured frame length, in lines.

## Operation
- Stage 1 registers hsync, vsync and rgb. A second copy of the sync signals detects leading edges (0->1) on the registered samples.
- h_cnt (12 bit): set to 0 on an hsync leading edge, otherwise increments. It saturates at 4095. Saturation counts as a timeout.
- On an hsync leading edge: h_total_meas <= h_cnt+1. The line is good if h_cnt+1 == H_TOTAL.
- v_cnt (11 bit): counts hsync leading edges. It is set to 0 on the hsync leading edge that coincides with a vsync leading edge, or follows it within the same line. It saturates at 2047.
- On a vsync leading edge: v_total_meas <= v_cnt+1. The frame is good if v_cnt+1 == V_TOTAL and every line in the frame was good.
- FSM states:
  - SEARCH (reset state): wait for a vsync leading edge, then go to CHECK with good_cnt=0.
  - CHECK: at each vsync edge, a good frame increments good_cnt; when good_cnt reaches LOCK_FRAMES, go to LOCKED. A bad frame sets good_cnt=0 and stays in CHECK.
  - LOCKED: any bad line, bad frame or timeout pulses err and returns to SEARCH.
  - A timeout in CHECK returns to SEARCH.
- Active region: pix_valid=1 when locked, h_cnt in [H_ACT_START, H_ACT_START+H_VALID-1] and v_cnt in [V_ACT_START, V_ACT_START+V_VALID-1].
  - pix_x = h_cnt - H_ACT_START.
  - pix_y = v_cnt - V_ACT_START.
  - pix_data = stage-1 rgb.
  - Outside the active region, pix_data=0 and pix_x/pix_y=0.
- Simultaneous hsync and vsync leading edges: hsync processing (line check) is applied first, then the frame check includes that line.

## Timing
- Reset values: pix_x=0, pix_y=0, pix_data=0, pix_valid=0, frame_start=0, locked=0, err=0, h_total_meas=0, v_total_meas=0. FSM=SEARCH, counters=0.
- Latency: pin sample to pix_data/pix_valid is 2 vga_clk cycles. frame_start and err are 2 cycles after the vsync (or offending) pin edge.
- locked is registered: it rises in the cycle after the LOCK_FRAMES-th good vsync edge is processed, and falls in the same cycle err pulses.
- Lock on clean input: first vsync edge, then LOCK_FRAMES full frames, so locked rises 2 frames plus 2-3 cycles after the first edge.
- Reset asserted mid-frame: all outputs return to reset values on the next edge. Lock is rebuilt from SEARCH.
- A single glitch line while locked: err pulse, locked=0. pix_valid stays low until relocked.

## Test plan
- Loopback from the VGA output path (800x525, sync active high, rgb = {pix_x[4:0],pix_y[5:0],pix_x[4:0]}) -> locked=1 after 2 full frames. pix_x/pix_y/pix_data match the generator for every active pixel. Exactly 307200 pix_valid cycles per frame.
- Same stream; check measurement outputs -> h_total_meas=800, v_total_meas=525. frame_start pulses once per 420000 cycles.
- Lock established, then one line shortened to 799 clocks -> err pulse 2 cycles later, locked=0. Relock after 2 further good frames.
- Wrong mode (H_TOTAL 1056 input) -> locked stays 0, pix_valid never asserted, h_total_meas=1056.
- hsync held low for 5000 cycles while locked -> timeout at h_cnt=4095, err pulse, FSM in SEARCH.
- sys_rst_n driven low for 3 cycles mid-frame while locked -> all outputs 0 on the next edge. Relock after 2 good frames.
